// File: rtl/clause_ctrl_pkg.sv
// Shared types and width helpers for the clause array controller.
// The optional slot-clear pass is enabled by defining CLAUSE_ARRAY_CTRL_CLR_EN.
package clause_ctrl_pkg;

    localparam int DEF_NUM_CLAUSES = 8;
    localparam int DEF_NUM_VARS    = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_LOAD     = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_OUT = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    // Each variable is encoded as a two-bit literal inside the clause word.
    function automatic int clause_width(input int num_vars);
        return num_vars * 2;
    endfunction

    // Occupancy must be able to represent a completely full array.
    function automatic int cnt_width(input int num_clauses);
        return $clog2(num_clauses) + 1;
    endfunction

    localparam int DEF_CLAUSE_W = DEF_NUM_VARS * 2;
    localparam int DEF_CNT_W    = $clog2(DEF_NUM_CLAUSES) + 1;

endpackage

// File: rtl/clause_slot_dec.sv
// Binary slot pointer plus enable to a one-hot slot strobe vector.
module clause_slot_dec #(
    parameter int NUM_CLAUSES = 8,
    parameter int PTR_W       = $clog2(NUM_CLAUSES)
) (
    input  logic                   i_en,
    input  logic [PTR_W-1:0]       i_ptr,
    output logic [NUM_CLAUSES-1:0] o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLAUSES; gi++) begin : g_slot
            assign o_onehot[gi] = i_en && (i_ptr == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/clause_array_ctrl.sv
// Load/dump sequencer for the clause storage array; sole driver of its wr/rd/data inputs.
// Define CLAUSE_ARRAY_CTRL_CLR_EN to zero every slot before each load session.
module clause_array_ctrl
    import clause_ctrl_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CNT   = cnt_width(NUM_CLAUSES)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_start_i,
    input  logic                               load_valid_i,
    output logic                               load_ready_o,
    input  logic [NUM_VARS*2-1:0]              load_clause_i,
    input  logic [WIDTH_C_LEN-1:0]             load_len_i,
    input  logic                               load_last_i,
    input  logic                               dump_start_i,
    output logic                               dump_valid_o,
    input  logic                               dump_ready_i,
    output logic [NUM_VARS*2-1:0]              dump_clause_o,
    output logic [WIDTH_C_LEN-1:0]             dump_len_o,
    output logic                               dump_last_o,
    output logic [NUM_CLAUSES-1:0]             wr_o,
    output logic [NUM_CLAUSES-1:0]             rd_o,
    output logic [NUM_VARS*2-1:0]              clause_o,
    output logic [WIDTH_C_LEN-1:0]             clause_len_o,
    input  logic [NUM_VARS*2-1:0]              clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
    output logic [WIDTH_CNT-1:0]               count_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               full_err_o
);

    localparam int CW    = clause_width(NUM_VARS);
    localparam int PTR_W = $clog2(NUM_CLAUSES);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(NUM_CLAUSES - 1);
    localparam logic [WIDTH_CNT-1:0] FULL_CNT = WIDTH_CNT'(NUM_CLAUSES);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic                   r_wr_en;
    logic [CW-1:0]          r_clause;
    logic [WIDTH_C_LEN-1:0] r_len;
    logic [WIDTH_CNT-1:0]   r_count;
    logic                   r_full_err;
    logic [CW-1:0]          r_dump_clause;
    logic [WIDTH_C_LEN-1:0] r_dump_len;
    logic                   r_dump_last;
    logic                   w_load_ready;
    logic                   w_load_fire;
    logic                   w_dump_valid;
    logic                   w_rd_en;
    logic                   w_clearing;
    logic [WIDTH_C_LEN-1:0] w_len_arr [NUM_CLAUSES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLAUSES; gi++) begin : g_len
            assign w_len_arr[gi] = clause_len_i[gi*WIDTH_C_LEN +: WIDTH_C_LEN];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_ready = 1'b0;
        w_dump_valid = 1'b0;
        w_rd_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start_i) begin
`ifdef CLAUSE_ARRAY_CTRL_CLR_EN
                    w_state_next = S_CLEAR;
`else
                    w_state_next = S_LOAD;
`endif
                end else if (dump_start_i) begin
                    w_state_next = (r_count == '0) ? S_FIN : S_DUMP_RD;
                end
            end
`ifdef CLAUSE_ARRAY_CTRL_CLR_EN
            S_CLEAR: begin
                if (r_ptr == PTR_LAST) w_state_next = S_LOAD;
            end
`endif
            S_LOAD: begin
                w_load_ready = (r_count < FULL_CNT);
                if (w_load_ready && load_valid_i && (load_last_i || r_ptr == PTR_LAST))
                    w_state_next = S_FIN;
            end
            S_DUMP_RD: begin
                w_rd_en      = 1'b1;
                w_state_next = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                w_dump_valid = 1'b1;
                if (dump_ready_i) w_state_next = r_dump_last ? S_FIN : S_DUMP_RD;
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_load_fire = w_load_ready && load_valid_i;

    // Writes land one cycle after the accept so clause_o/clause_len_o come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr         <= '0;
            r_wr_ptr      <= '0;
            r_wr_en       <= 1'b0;
            r_clause      <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_full_err    <= 1'b0;
            r_dump_clause <= '0;
            r_dump_len    <= '0;
            r_dump_last   <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_full_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_start_i) begin
                        r_count <= '0;
                        r_ptr   <= '0;
`ifdef CLAUSE_ARRAY_CTRL_CLR_EN
                        r_clause <= '0;
                        r_len    <= '0;
`endif
                    end else if (dump_start_i) begin
                        r_ptr <= '0;
                    end
                end
`ifdef CLAUSE_ARRAY_CTRL_CLR_EN
                S_CLEAR: r_ptr <= r_ptr + 1'b1;
`endif
                S_LOAD: begin
                    if (w_load_fire) begin
                        r_wr_en    <= 1'b1;
                        r_wr_ptr   <= r_ptr;
                        r_clause   <= load_clause_i;
                        r_len      <= load_len_i;
                        r_ptr      <= r_ptr + 1'b1;
                        r_count    <= r_count + 1'b1;
                        r_full_err <= !load_last_i && (r_ptr == PTR_LAST);
                    end
                end
                S_DUMP_RD: begin
                    r_dump_clause <= clause_i;
                    r_dump_len    <= w_len_arr[r_ptr];
                    r_dump_last   <= (WIDTH_CNT'(r_ptr) == r_count - 1'b1);
                end
                S_DUMP_OUT: begin
                    if (dump_ready_i && !r_dump_last) r_ptr <= r_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_clearing = (r_state == S_CLEAR);

    clause_slot_dec #(.NUM_CLAUSES(NUM_CLAUSES), .PTR_W(PTR_W)) u_wr_dec (
        .i_en     (r_wr_en || w_clearing),
        .i_ptr    (w_clearing ? r_ptr : r_wr_ptr),
        .o_onehot (wr_o)
    );

    clause_slot_dec #(.NUM_CLAUSES(NUM_CLAUSES), .PTR_W(PTR_W)) u_rd_dec (
        .i_en     (w_rd_en),
        .i_ptr    (r_ptr),
        .o_onehot (rd_o)
    );

    assign load_ready_o  = w_load_ready;
    assign dump_valid_o  = w_dump_valid;
    assign dump_clause_o = r_dump_clause;
    assign dump_len_o    = r_dump_len;
    assign dump_last_o   = r_dump_last && w_dump_valid;
    assign clause_o      = r_clause;
    assign clause_len_o  = r_len;
    assign count_o       = r_count;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_FIN);
    assign full_err_o    = r_full_err;

endmodule

// File: tb/tb_clause_array_ctrl.sv
// Self-checking bench for clause_array_ctrl with a behavioural clause array model.
// Also valid with CLAUSE_ARRAY_CTRL_CLR_EN defined (expects the clear walk before loads).
module tb_clause_array_ctrl;

    localparam int NC   = 8;
    localparam int CW   = 16;
    localparam int LW   = 4;
    localparam int CNTW = 4;

    typedef struct {
        int            slot;
        logic [CW-1:0] c;
        logic [LW-1:0] l;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start_i, load_valid_i, load_ready_o, load_last_i;
    logic [CW-1:0]   load_clause_i;
    logic [LW-1:0]   load_len_i;
    logic            dump_start_i, dump_valid_o, dump_ready_i, dump_last_o;
    logic [CW-1:0]   dump_clause_o;
    logic [LW-1:0]   dump_len_o;
    logic [NC-1:0]   wr_o, rd_o;
    logic [CW-1:0]   clause_o, clause_i;
    logic [LW-1:0]   clause_len_o;
    logic [LW*NC-1:0] clause_len_i;
    logic [CNTW-1:0] count_o;
    logic            busy_o, done_o, full_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] mem_c [NC];
    logic [LW-1:0] mem_l [NC];
    logic [CW-1:0] exp_c [NC];
    logic [LW-1:0] exp_l [NC];
    int            exp_count = 0;
    beat_t         wr_q[$];
    beat_t         dump_q[$];

    always #5 clk = ~clk;

    clause_array_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .load_start_i  (load_start_i),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .load_clause_i (load_clause_i),
        .load_len_i    (load_len_i),
        .load_last_i   (load_last_i),
        .dump_start_i  (dump_start_i),
        .dump_valid_o  (dump_valid_o),
        .dump_ready_i  (dump_ready_i),
        .dump_clause_o (dump_clause_o),
        .dump_len_o    (dump_len_o),
        .dump_last_o   (dump_last_o),
        .wr_o          (wr_o),
        .rd_o          (rd_o),
        .clause_o      (clause_o),
        .clause_len_o  (clause_len_o),
        .clause_i      (clause_i),
        .clause_len_i  (clause_len_i),
        .count_o       (count_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .full_err_o    (full_err_o)
    );

    // Behavioural clause array: one-hot write, OR-reduced combinational read.
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (wr_o[i]) begin
                mem_c[i] <= clause_o;
                mem_l[i] <= clause_len_o;
            end
        end
    end

    always_comb begin
        clause_i     = '0;
        clause_len_i = '0;
        for (int i = 0; i < NC; i++) begin
            if (rd_o[i]) clause_i = clause_i | mem_c[i];
            clause_len_i[i*LW +: LW] = mem_l[i];
        end
    end

    task automatic drive_idle();
        load_start_i  = 1'b0;
        load_valid_i  = 1'b0;
        load_last_i   = 1'b0;
        load_clause_i = '0;
        load_len_i    = '0;
        dump_start_i  = 1'b0;
        dump_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (count_o !== '0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d exp=0", count_o);
        end
        n_checks++;
        if ({wr_o, rd_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_strobes got wr=%h rd=%h exp=0", wr_o, rd_o);
        end
        n_checks++;
        if ({busy_o, done_o, full_err_o, load_ready_o, dump_valid_o, dump_last_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy_o, done_o, full_err_o, load_ready_o, dump_valid_o, dump_last_o});
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy got=%b exp=0", busy_o);
        end
        exp_count = 0;
    endtask

    task automatic test_dump_empty();
        int done_seen = 0;
        dump_start_i = 1'b1;
        @(negedge clk);
        dump_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_o !== '0 || dump_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL dump_empty_quiet got rd=%h valid=%b exp rd=0 valid=0", rd_o, dump_valid_o);
            end
            if (done_o === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (done_seen != 1) begin
            n_fail++;
            $display("FAIL dump_empty_done got=%0d pulses exp=1", done_seen);
        end
        $display("dump empty: done pulses=%0d", done_seen);
    endtask

    task automatic test_load(input int n, input bit with_last, input bit both);
        beat_t         b_exp;
        logic [CW-1:0] c;
        logic [LW-1:0] l;
        logic [LW-1:0] lens3 [3];
        logic [NC-1:0] oh;
        lens3[0] = 4'd2;
        lens3[1] = 4'd3;
        lens3[2] = 4'd1;
        load_start_i = 1'b1;
        dump_start_i = both;
        @(negedge clk);
        load_start_i = 1'b0;
        dump_start_i = 1'b0;
`ifdef CLAUSE_ARRAY_CTRL_CLR_EN
        for (int k = 0; k < NC; k++) begin
            oh = NC'(1) << k;
            n_checks++;
            if ({wr_o, clause_o, clause_len_o, load_ready_o} !== {oh, 16'h0, 4'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL clear_walk k=%0d got wr=%h c=%h l=%h rdy=%b exp wr=%h zero data rdy=0",
                         k, wr_o, clause_o, clause_len_o, load_ready_o, oh);
            end
            @(negedge clk);
        end
`endif
        for (int b = 0; b <= n; b++) begin
            n_checks++;
            if (rd_o !== '0 || dump_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load_no_rd got rd=%h valid=%b exp 0", rd_o, dump_valid_o);
            end
            if (wr_q.size() > 0) begin
                b_exp = wr_q.pop_front();
                oh = NC'(1) << b_exp.slot;
                n_checks++;
                if ({wr_o, clause_o, clause_len_o} !== {oh, b_exp.c, b_exp.l}) begin
                    n_fail++;
                    $display("FAIL load_write slot=%0d got wr=%h c=%h l=%0d exp wr=%h c=%h l=%0d",
                             b_exp.slot, wr_o, clause_o, clause_len_o, oh, b_exp.c, b_exp.l);
                end
                $display("write slot=%0d clause=%h len=%0d", b_exp.slot, clause_o, clause_len_o);
            end else begin
                n_checks++;
                if (wr_o !== '0) begin
                    n_fail++;
                    $display("FAIL load_wr_idle got=%h exp=0", wr_o);
                end
            end
            if (b < n) begin
                n_checks++;
                if ({load_ready_o, busy_o, done_o} !== 3'b110 || count_o !== CNTW'(b)) begin
                    n_fail++;
                    $display("FAIL load_beat b=%0d got rdy/busy/done=%b cnt=%0d exp 110 cnt=%0d",
                             b, {load_ready_o, busy_o, done_o}, count_o, b);
                end
                c = CW'($urandom);
                l = (n == 3) ? lens3[b] : LW'($urandom);
                load_valid_i  = 1'b1;
                load_clause_i = c;
                load_len_i    = l;
                load_last_i   = with_last && (b == n - 1);
                load_start_i  = both && (b == 1);
                dump_start_i  = both && (b == 1);
                exp_c[b] = c;
                exp_l[b] = l;
                wr_q.push_back('{b, c, l, 1'b0});
                @(negedge clk);
            end else begin
                drive_idle();
                n_checks++;
                if ({done_o, full_err_o, load_ready_o} !== {1'b1, !with_last && n == NC, 1'b0}
                    || count_o !== CNTW'(n)) begin
                    n_fail++;
                    $display("FAIL load_fin got done/err/rdy=%b cnt=%0d exp %b cnt=%0d",
                             {done_o, full_err_o, load_ready_o}, count_o,
                             {1'b1, !with_last && n == NC, 1'b0}, n);
                end
                @(negedge clk);
                n_checks++;
                if ({done_o, full_err_o, busy_o} !== 3'b000 || wr_o !== '0 || count_o !== CNTW'(n)) begin
                    n_fail++;
                    $display("FAIL load_after got done/err/busy=%b wr=%h cnt=%0d exp 000 wr=0 cnt=%0d",
                             {done_o, full_err_o, busy_o}, wr_o, count_o, n);
                end
            end
        end
        exp_count = n;
    endtask

    task automatic test_dump(input int stall0);
        beat_t         b_exp;
        logic [NC-1:0] oh;
        int            stall;
        dump_start_i = 1'b1;
        @(negedge clk);
        dump_start_i = 1'b0;
        for (int k = 0; k < exp_count; k++)
            dump_q.push_back('{k, exp_c[k], exp_l[k], k == exp_count - 1});
        for (int k = 0; k < exp_count; k++) begin
            dump_ready_i = 1'b0;
            oh = NC'(1) << k;
            n_checks++;
            if (rd_o !== oh || wr_o !== '0 || dump_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL dump_read k=%0d got rd=%h wr=%h valid=%b busy=%b exp rd=%h wr=0 valid=0 busy=1",
                         k, rd_o, wr_o, dump_valid_o, busy_o, oh);
            end
            @(negedge clk);
            b_exp = dump_q.pop_front();
            stall = (k == 0) ? stall0 : 0;
            for (int s = 0; s <= stall; s++) begin
                n_checks++;
                if ({dump_valid_o, dump_clause_o, dump_len_o, dump_last_o} !== {1'b1, b_exp.c, b_exp.l, b_exp.last}
                    || rd_o !== '0) begin
                    n_fail++;
                    $display("FAIL dump_beat k=%0d s=%0d got v=%b c=%h l=%0d last=%b rd=%h exp v=1 c=%h l=%0d last=%b rd=0",
                             k, s, dump_valid_o, dump_clause_o, dump_len_o, dump_last_o, rd_o,
                             b_exp.c, b_exp.l, b_exp.last);
                end
                if (s == stall) begin
                    dump_ready_i = 1'b1;
                    $display("dump slot=%0d clause=%h len=%0d last=%b", k, dump_clause_o, dump_len_o, dump_last_o);
                end
                @(negedge clk);
            end
        end
        dump_ready_i = 1'b0;
        n_checks++;
        if ({done_o, dump_valid_o} !== 2'b10 || rd_o !== '0 || count_o !== CNTW'(exp_count)) begin
            n_fail++;
            $display("FAIL dump_fin got done/valid=%b rd=%h cnt=%0d exp 10 rd=0 cnt=%0d",
                     {done_o, dump_valid_o}, rd_o, count_o, exp_count);
        end
        @(negedge clk);
        n_checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL dump_after got busy/done=%b exp 00", {busy_o, done_o});
        end
    endtask

    task automatic test_reset_mid_dump();
        int done_seen = 0;
        dump_start_i = 1'b1;
        @(negedge clk);
        dump_start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dump_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got valid=%b exp=1", dump_valid_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dump_valid_o, dump_clause_o, dump_len_o, dump_last_o, rd_o, wr_o, clause_o, clause_len_o,
             count_o, busy_o, done_o, full_err_o, load_ready_o} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got v=%b dc=%h dl=%0d last=%b rd=%h wr=%h c=%h l=%0d cnt=%0d busy=%b done=%b exp all 0",
                     dump_valid_o, dump_clause_o, dump_len_o, dump_last_o, rd_o, wr_o, clause_o,
                     clause_len_o, count_o, busy_o, done_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) rst = 1'b1;
            if (done_o === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (done_seen != 0 || busy_o !== 1'b0 || count_o !== '0) begin
            n_fail++;
            $display("FAIL midrst_after got done pulses=%0d busy=%b cnt=%0d exp 0 0 0", done_seen, busy_o, count_o);
        end
        exp_count = 0;
        $display("reset mid-dump: done pulses=%0d", done_seen);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_dump_empty();
        test_load(3, 1'b1, 1'b0);
        test_dump(4);
        test_load(NC, 1'b0, 1'b1);
        test_load(3, 1'b1, 1'b0);
        test_dump(0);
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
